// File: rtl/bpred_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : bpred_update_sched
// Purpose  : Update scheduler and write-port arbiter for the branch predictor
//            tables. Execute-stage resolution updates are buffered in a small
//            FIFO and drained into the single table write port whenever fetch
//            does not need it, or unconditionally once the queue reaches its
//            high-water mark. After reset an optional clearing sweep writes
//            every table index once before normal operation begins.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk, reset (sync, active-low)
//            execute_bpredictor_*  : update push (valid, PC4, dir, miss, meta)
//            upd_ready             : FIFO not full
//            fetch_lookup          : fetch wants the table port
//            fetch_stall           : fetch lookup denied this cycle
//            tbl_we/tbl_waddr/tbl_wdir/tbl_wmiss/tbl_wmeta/tbl_wclear
//                                  : registered table write port
//            init_done             : clearing sweep finished
//            upd_count             : FIFO occupancy
// Macro    : BPRED_INIT_SWEEP_EN - when defined, reset enters the clearing
//            sweep; when undefined, reset goes straight to draining and
//            tbl_wclear is tied low.
// ============================================================================
module bpred_update_sched #(
    parameter int IDX_W   = 10,
    parameter int DEPTH   = 4,
    parameter int HIWATER = 3,
    parameter int META_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     execute_bpredictor_update,
    input  logic [31:0]              execute_bpredictor_PC4,
    input  logic                     execute_bpredictor_dir,
    input  logic                     execute_bpredictor_miss,
    input  logic [META_W-1:0]        execute_bpredictor_meta,
    output logic                     upd_ready,
    input  logic                     fetch_lookup,
    output logic                     fetch_stall,
    output logic                     tbl_we,
    output logic [IDX_W-1:0]         tbl_waddr,
    output logic                     tbl_wdir,
    output logic                     tbl_wmiss,
    output logic [META_W-1:0]        tbl_wmeta,
    output logic                     tbl_wclear,
    output logic                     init_done,
    output logic [$clog2(DEPTH):0]   upd_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + 2 + META_W;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HIWATER_C = CNT_W'(HIWATER);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]       state;
    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] head;
    logic [IDX_W-1:0] push_idx;
    logic             push;
    logic             pop;
    logic             in_init;
    logic             unused_pc;

    // ((PC4 - 4) >> 2) truncated to IDX_W bits equals PC4[IDX_W+1:2] - 1
    // modulo 2^IDX_W, since subtracting 4 never disturbs bits [1:0].
    // PC4 = 0 therefore wraps to all ones.
    assign push_idx  = execute_bpredictor_PC4[IDX_W+1:2] - IDX_W'(1);
    assign unused_pc = ^{execute_bpredictor_PC4[31:IDX_W+2], execute_bpredictor_PC4[1:0]};

    assign in_init   = (state == ST_INIT);
    assign upd_ready = (upd_count != DEPTH_C);
    assign push      = execute_bpredictor_update && upd_ready;
    // Fetch owns the port unless the queue has backed up to the high-water mark.
    assign pop       = !in_init && (upd_count != '0) &&
                       (!fetch_lookup || (upd_count >= HIWATER_C));
    assign fetch_stall = in_init || (fetch_lookup && pop);
    assign head      = fifo_mem[rd_ptr];

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= {push_idx, execute_bpredictor_dir,
                                 execute_bpredictor_miss, execute_bpredictor_meta};
        end
    end

`ifdef BPRED_INIT_SWEEP_EN
    logic [IDX_W-1:0] sweep_ptr;
    logic             wclear_q;

    assign tbl_wclear = wclear_q;
`else
    assign tbl_wclear = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef BPRED_INIT_SWEEP_EN
            state     <= ST_INIT;
            sweep_ptr <= '0;
            wclear_q  <= 1'b0;
`else
            state     <= ST_DRAIN;
`endif
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            upd_count <= '0;
            tbl_we    <= 1'b0;
            tbl_waddr <= '0;
            tbl_wdir  <= 1'b0;
            tbl_wmiss <= 1'b0;
            tbl_wmeta <= '0;
            init_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            upd_count <= upd_count + CNT_W'(push) - CNT_W'(pop);

`ifdef BPRED_INIT_SWEEP_EN
            if (state == ST_INIT) begin
                // One clearing write per cycle; payload fields are don't-care.
                tbl_we    <= 1'b1;
                wclear_q  <= 1'b1;
                tbl_waddr <= sweep_ptr;
                tbl_wdir  <= 1'b0;
                tbl_wmiss <= 1'b0;
                tbl_wmeta <= '0;
                sweep_ptr <= sweep_ptr + IDX_W'(1);
                if (sweep_ptr == {IDX_W{1'b1}}) begin
                    state     <= ST_DRAIN;
                    init_done <= 1'b1;
                end
            end else
`endif
            begin
                init_done <= 1'b1;
`ifdef BPRED_INIT_SWEEP_EN
                wclear_q  <= 1'b0;
`endif
                if (pop) begin
                    tbl_we <= 1'b1;
                    {tbl_waddr, tbl_wdir, tbl_wmiss, tbl_wmeta} <= head;
                end else begin
                    tbl_we <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
